// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing for hazards forwarding cannot cover: load-use, MDU
// occupancy of EX, data-memory wait states and taken-branch flushes.
module hazard_stall_controller #(
   parameter int MDU_LATENCY = 4,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  IF_ID_rs1,
   input  logic [4:0]  IF_ID_rs2,
   input  logic        IF_ID_uses_rs1,
   input  logic        IF_ID_uses_rs2,
   input  logic [4:0]  ID_EX_rd,
   input  logic        ID_EX_mem_read,
   input  logic        mdu_start,
   input  logic        branch_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_write,
   output logic        IF_ID_write,
   output logic        ID_EX_write,
   output logic        ID_EX_bubble,
   output logic        IF_ID_flush,
   output logic        ID_EX_flush,
   output logic        EX_MEM_write,
   output logic        EX_MEM_bubble,
   output logic        MEM_WB_write,
   output logic        mdu_busy,
   output logic        mdu_done,
   output logic [31:0] perf_stall_cycles
);

   typedef enum logic {RUN, MDU_WAIT} state_t;

   // First MDU cycle is spent in RUN, so the countdown starts two short.
   localparam int WAIT_INIT = (MDU_LATENCY > 1) ? MDU_LATENCY - 2 : 0;

   state_t            state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [31:0]       perf_reg;

   logic freeze;
   logic load_use;

   assign freeze   = dmem_req & ~dmem_ready;
   assign load_use = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                     ((IF_ID_uses_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                      (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

   always_comb begin
      pc_write      = 1'b1;
      IF_ID_write   = 1'b1;
      ID_EX_write   = 1'b1;
      ID_EX_bubble  = 1'b0;
      IF_ID_flush   = 1'b0;
      ID_EX_flush   = 1'b0;
      EX_MEM_write  = 1'b1;
      EX_MEM_bubble = 1'b0;
      MEM_WB_write  = 1'b1;
      mdu_busy      = 1'b0;
      mdu_done      = 1'b0;
      if (rst) begin
         pc_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_write  = 1'b0;
         EX_MEM_write = 1'b0;
         MEM_WB_write = 1'b0;
         ID_EX_bubble = 1'b1;
         IF_ID_flush  = 1'b1;
         ID_EX_flush  = 1'b1;
      end else begin
         mdu_busy = (state_reg == MDU_WAIT);
         if (freeze) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
         end else if (state_reg == RUN) begin
            if (branch_taken) begin
               IF_ID_flush = 1'b1;
               ID_EX_flush = 1'b1;
            end else if (mdu_start && MDU_LATENCY > 1) begin
               pc_write      = 1'b0;
               IF_ID_write   = 1'b0;
               ID_EX_write   = 1'b0;
               EX_MEM_bubble = 1'b1;
            end else if (mdu_start) begin
               mdu_done = 1'b1;
            end else if (load_use) begin
               pc_write     = 1'b0;
               IF_ID_write  = 1'b0;
               ID_EX_bubble = 1'b1;
            end
         end else if (cnt_reg != '0) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_bubble = 1'b1;
         end else begin
            mdu_done = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
         cnt_reg   <= '0;
         perf_reg  <= '0;
      end else begin
         if (!pc_write && perf_reg != 32'hFFFF_FFFF)
            perf_reg <= perf_reg + 32'd1;
         if (!freeze) begin
            if (state_reg == RUN) begin
               if (!branch_taken && mdu_start && MDU_LATENCY > 1) begin
                  state_reg <= MDU_WAIT;
                  cnt_reg   <= CNT_W'(WAIT_INIT);
               end
            end else if (cnt_reg != '0) begin
               cnt_reg <= cnt_reg - 1'b1;
            end else begin
               state_reg <= RUN;
            end
         end
      end
   end

   assign perf_stall_cycles = perf_reg;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench: the driver queues the expected control word for each
// cycle and a monitor compares it against the DUT in the low clock phase.
module tb_hazard_stall_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
   logic        IF_ID_uses_rs1, IF_ID_uses_rs2, ID_EX_mem_read;
   logic        mdu_start, branch_taken, dmem_req, dmem_ready;
   logic        pc_write, IF_ID_write, ID_EX_write, ID_EX_bubble;
   logic        IF_ID_flush, ID_EX_flush, EX_MEM_write, EX_MEM_bubble;
   logic        MEM_WB_write, mdu_busy, mdu_done;
   logic [31:0] perf_stall_cycles;

   always #5 clk = ~clk;

   hazard_stall_controller #(.MDU_LATENCY(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
      .IF_ID_uses_rs1(IF_ID_uses_rs1), .IF_ID_uses_rs2(IF_ID_uses_rs2),
      .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read),
      .mdu_start(mdu_start), .branch_taken(branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
      .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush),
      .ID_EX_flush(ID_EX_flush), .EX_MEM_write(EX_MEM_write),
      .EX_MEM_bubble(EX_MEM_bubble), .MEM_WB_write(MEM_WB_write),
      .mdu_busy(mdu_busy), .mdu_done(mdu_done),
      .perf_stall_cycles(perf_stall_cycles)
   );

   // {pc, ifid_w, idex_w, idex_bub, ifid_fl, idex_fl, exmem_w, exmem_bub, memwb_w, busy, done}
   localparam logic [10:0] NORM = 11'b111_000_1_0_1_0_0;
   localparam logic [10:0] RSTV = 11'b000_111_0_0_0_0_0;
   localparam logic [10:0] FRZ  = 11'b000_000_0_0_0_0_0;
   localparam logic [10:0] FRZB = 11'b000_000_0_0_0_1_0;
   localparam logic [10:0] BR   = 11'b111_011_1_0_1_0_0;
   localparam logic [10:0] LU   = 11'b001_100_1_0_1_0_0;
   localparam logic [10:0] MS   = 11'b000_000_1_1_1_0_0;
   localparam logic [10:0] WT   = 11'b000_000_1_1_1_1_0;
   localparam logic [10:0] DN   = 11'b111_000_1_0_1_1_1;

   typedef struct {
      string       name;
      logic [10:0] outs;
      logic [31:0] perf;
      bit          perf_known;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_perf = '0;
   bit          perf_known = 1'b0;
   bit          done_driving = 1'b0;

   wire [10:0] act = {pc_write, IF_ID_write, ID_EX_write, ID_EX_bubble,
                      IF_ID_flush, ID_EX_flush, EX_MEM_write, EX_MEM_bubble,
                      MEM_WB_write, mdu_busy, mdu_done};

   task automatic cyc(input string name, input logic r,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic mr,
                      input logic ms, input logic br,
                      input logic dreq, input logic drdy,
                      input logic [10:0] e);
      exp_t x;
      @(negedge clk);
      rst = r; IF_ID_rs1 = rs1; IF_ID_uses_rs1 = u1;
      IF_ID_rs2 = rs2; IF_ID_uses_rs2 = u2; ID_EX_rd = rd;
      ID_EX_mem_read = mr; mdu_start = ms; branch_taken = br;
      dmem_req = dreq; dmem_ready = drdy;
      x.name = name; x.outs = e; x.perf = exp_perf; x.perf_known = perf_known;
      sb.push_back(x);
      if (r) begin
         exp_perf   = '0;
         perf_known = 1'b1;
      end else if (!e[10] && exp_perf != 32'hFFFF_FFFF) begin
         exp_perf = exp_perf + 32'd1;
      end
   endtask

   task automatic idle(input string name, input logic [10:0] e);
      cyc(name, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
   endtask

   // Monitor: compares one queued expectation per cycle, 1 time unit after negedge.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         #1;
         if (sb.size() != 0) begin
            x = sb.pop_front();
            checks++;
            if (act !== x.outs) begin
               errors++;
               $display("FAIL %s outs actual=%b required=%b", x.name, act, x.outs);
            end
            if (x.perf_known) begin
               checks++;
               if (perf_stall_cycles !== x.perf) begin
                  errors++;
                  $display("FAIL %s perf actual=%h required=%h", x.name,
                           perf_stall_cycles, x.perf);
               end
            end
            $display("cycle %-12s outs=%b perf=%0d", x.name, act, perf_stall_cycles);
         end
      end
   end

   initial begin
      int budget;
      cyc("reset0", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RSTV);
      cyc("reset1", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RSTV);
      idle("idle", NORM);
      // load-use via rs2, then via rs1; non-hazards
      cyc("lu_rs2", 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU);
      idle("lu_after", NORM);
      cyc("lu_rd0", 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
      cyc("lu_unused", 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
      cyc("lu_rs1", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU);
      cyc("lu_noload", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
      // MDU op, branch during wait is ignored
      cyc("mdu_start", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MS);
      idle("mdu_w2", WT);
      cyc("mdu_w1_br", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WT);
      idle("mdu_done", DN);
      idle("mdu_after", NORM);
      // freeze for two cycles during MDU_WAIT
      cyc("fz_start", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MS);
      idle("fz_w2", WT);
      cyc("fz_hold0", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZB);
      cyc("fz_hold1", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZB);
      cyc("fz_w1", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, WT);
      idle("fz_done", DN);
      // freeze in RUN masks a branch; branch beats load-use and mdu_start
      cyc("fz_run_br", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ);
      cyc("br_all", 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, BR);
      idle("br_run", NORM);
      // reset while cnt=1 in MDU_WAIT
      cyc("rs_start", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MS);
      idle("rs_w2", WT);
      cyc("rs_mid", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RSTV);
      cyc("rs_hold", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RSTV);
      idle("rs_run", NORM);
      // saturation from a preloaded count
      #2;
      force dut.perf_reg = 32'hFFFF_FFFE;
      #1;
      release dut.perf_reg;
      exp_perf = 32'hFFFF_FFFE;
      cyc("sat0", 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU);
      cyc("sat1", 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU);
      cyc("sat2", 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU);
      idle("sat_end", NORM);

      budget = 0;
      while (sb.size() != 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending actual=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
